// File: rtl/hazard_pipe_ctrl_if.sv
// hazard_pipe_ctrl_if: ID-side request signals and the EX/MEM/WB view handed to forwarding_unit.
interface hazard_pipe_ctrl_if;
  logic [31:0] instruction_ID;
  logic        valid_ID;
  logic        RegWrite_ID;
  logic        MemRead_ID;
  logic        flush_EX;
  logic [31:0] instruction_EX;
  logic [31:0] instruction_MEM;
  logic [31:0] instruction_WB;
  logic        RegWrite_MEM;
  logic        RegWrite_WB;
  logic        stall_ID;
  logic        mul_busy;

  // Pipeline front end: drives the decoded instruction, observes stages and stalls.
  modport master (
    output instruction_ID, valid_ID, RegWrite_ID, MemRead_ID, flush_EX,
    input  instruction_EX, instruction_MEM, instruction_WB,
    input  RegWrite_MEM, RegWrite_WB, stall_ID, mul_busy
  );

  // Hazard controller side.
  modport slave (
    input  instruction_ID, valid_ID, RegWrite_ID, MemRead_ID, flush_EX,
    output instruction_EX, instruction_MEM, instruction_WB,
    output RegWrite_MEM, RegWrite_WB, stall_ID, mul_busy
  );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: holds the EX/MEM/WB instruction and RegWrite registers feeding
// forwarding_unit, stalls on load-use hazards and while a multi-cycle MUL sits in EX,
// inserts bubbles and applies branch flushes.
//
// The MUL wait is entered on the edge that loads the MUL into EX, so the FSM is in
// MUL_WAIT for the first MUL_LAT-1 EX cycles of the MUL (stall_ID and mul_busy high)
// and back in RUN for its last EX cycle, where the pipe advances normally. A second
// MUL arriving on that advance re-enters MUL_WAIT immediately, so there is no gap.
module hazard_pipe_ctrl #(
  parameter int          MUL_LAT = 3,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input logic               clk,
  input logic               rst,
  hazard_pipe_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  localparam bit         MUL_STALLS = (MUL_LAT > 1);
  localparam int         CNT_INIT_I = MUL_STALLS ? (MUL_LAT - 2) : 0;
  localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

  // M-extension MUL: OP opcode with funct7 = 0000001.
  function automatic logic is_mul(input logic [31:0] ins);
    return (ins[6:0] == 7'b0110011) && (ins[31:25] == 7'b0000001);
  endfunction

  state_t      state_r, state_nx;
  logic [3:0]  cnt_r, cnt_nx;
  logic [31:0] ex_instr_r, ex_instr_nx;
  logic        ex_rw_r, ex_rw_nx;
  logic        ex_mr_r, ex_mr_nx;
  logic [31:0] mem_instr_r, mem_instr_nx;
  logic        mem_rw_r, mem_rw_nx;
  logic [31:0] wb_instr_r, wb_instr_nx;
  logic        wb_rw_r, wb_rw_nx;
  logic        mul_busy_r;
  logic        stall_s;
  logic        loaduse_s;
  logic [4:0]  rd_ex_s;

  // Load in EX whose destination is read by the instruction in ID (both rs fields checked).
  always_comb begin
    rd_ex_s   = ex_instr_r[11:7];
    loaduse_s = (state_r == RUN) && ex_mr_r && (rd_ex_s != 5'd0) && bus.valid_ID &&
                ((rd_ex_s == bus.instruction_ID[19:15]) || (rd_ex_s == bus.instruction_ID[24:20]));
  end

  // Next-state and next-stage selection: flush > load-use > normal in RUN; hold EX in MUL_WAIT.
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = cnt_r;
    ex_instr_nx  = ex_instr_r;
    ex_rw_nx     = ex_rw_r;
    ex_mr_nx     = ex_mr_r;
    mem_instr_nx = ex_instr_r;
    mem_rw_nx    = ex_rw_r & (ex_instr_r[11:7] != 5'd0);
    wb_instr_nx  = mem_instr_r;
    wb_rw_nx     = mem_rw_r;
    stall_s      = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.flush_EX) begin
          ex_instr_nx = NOP;
          ex_rw_nx    = 1'b0;
          ex_mr_nx    = 1'b0;
        end else if (loaduse_s) begin
          ex_instr_nx = NOP;
          ex_rw_nx    = 1'b0;
          ex_mr_nx    = 1'b0;
          stall_s     = 1'b1;
        end else if (bus.valid_ID) begin
          ex_instr_nx = bus.instruction_ID;
          ex_rw_nx    = bus.RegWrite_ID;
          ex_mr_nx    = bus.MemRead_ID;
          if (MUL_STALLS && is_mul(bus.instruction_ID)) begin
            state_nx = MUL_WAIT;
            cnt_nx   = CNT_INIT;
          end else begin
            state_nx = RUN;
            cnt_nx   = 4'd0;
          end
        end else begin
          ex_instr_nx = NOP;
          ex_rw_nx    = 1'b0;
          ex_mr_nx    = 1'b0;
        end
      end
      MUL_WAIT: begin
        stall_s      = 1'b1;
        mem_instr_nx = NOP;
        mem_rw_nx    = 1'b0;
        if (cnt_r == 4'd0) begin
          state_nx = RUN;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nx    = RUN;
        cnt_nx      = 4'd0;
        ex_instr_nx = NOP;
        ex_rw_nx    = 1'b0;
        ex_mr_nx    = 1'b0;
      end
    endcase
  end

  // Pipeline stage, FSM and busy-flag registers; reset turns every stage into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      cnt_r       <= 4'd0;
      ex_instr_r  <= NOP;
      ex_rw_r     <= 1'b0;
      ex_mr_r     <= 1'b0;
      mem_instr_r <= NOP;
      mem_rw_r    <= 1'b0;
      wb_instr_r  <= NOP;
      wb_rw_r     <= 1'b0;
      mul_busy_r  <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cnt_r       <= cnt_nx;
      ex_instr_r  <= ex_instr_nx;
      ex_rw_r     <= ex_rw_nx;
      ex_mr_r     <= ex_mr_nx;
      mem_instr_r <= mem_instr_nx;
      mem_rw_r    <= mem_rw_nx;
      wb_instr_r  <= wb_instr_nx;
      wb_rw_r     <= wb_rw_nx;
      mul_busy_r  <= (state_nx == MUL_WAIT);
    end
  end

  assign bus.instruction_EX  = ex_instr_r;
  assign bus.instruction_MEM = mem_instr_r;
  assign bus.instruction_WB  = wb_instr_r;
  assign bus.RegWrite_MEM    = mem_rw_r;
  assign bus.RegWrite_WB     = wb_rw_r;
  assign bus.stall_ID        = stall_s & ~rst;
  assign bus.mul_busy        = mul_busy_r;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb_hazard_pipe_ctrl: directed scenarios plus randomized traffic checked against a
// cycle-level model of the pipe (two instances: MUL_LAT=3 and MUL_LAT=1).
module tb_hazard_pipe_ctrl;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          LAT0  = 3;
  localparam int          LAT1  = 1;
  localparam logic [31:0] LW5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD6  = 32'h0022_8333; // add  x6,x5,x2
  localparam logic [31:0] MUL7  = 32'h0241_83B3; // mul  x7,x3,x4
  localparam logic [31:0] ADDI8 = 32'h0013_8413; // addi x8,x7,1
  localparam logic [31:0] ADDI9 = 32'h0010_0493; // addi x9,x0,1
  localparam logic [31:0] X0W   = 32'h0050_8013; // addi x0,x1,5

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] id_ins = NOP;
  logic id_v = 1'b0, id_rw = 1'b0, id_mr = 1'b0, fl = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_pipe_ctrl_if bus0();
  hazard_pipe_ctrl_if bus1();
  assign bus0.instruction_ID = id_ins;
  assign bus0.valid_ID       = id_v;
  assign bus0.RegWrite_ID    = id_rw;
  assign bus0.MemRead_ID     = id_mr;
  assign bus0.flush_EX       = fl;
  assign bus1.instruction_ID = id_ins;
  assign bus1.valid_ID       = id_v;
  assign bus1.RegWrite_ID    = id_rw;
  assign bus1.MemRead_ID     = id_mr;
  assign bus1.flush_EX       = fl;

  hazard_pipe_ctrl #(.MUL_LAT(LAT0), .NOP(NOP)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  hazard_pipe_ctrl #(.MUL_LAT(LAT1), .NOP(NOP)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------- reference model ----------------
  // Each instance: contents of EX/MEM/WB and how many EX cycles the EX occupant still needs.
  logic [31:0] m_ex[2], m_mem[2], m_wb[2];
  logic        m_exrw[2], m_exmr[2], m_memrw[2], m_wbrw[2];
  int          m_left[2];

  function automatic int lat_of(int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit is_mul(logic [31:0] i);
    return (i[6:0] == 7'b0110011) && (i[31:25] == 7'b0000001);
  endfunction

  function automatic bit m_lu(int k);
    logic [4:0] rd;
    rd = m_ex[k][11:7];
    return (m_left[k] <= 1) && m_exmr[k] && (rd != 5'd0) && id_v &&
           ((rd == id_ins[19:15]) || (rd == id_ins[24:20]));
  endfunction

  function automatic bit m_stall(int k);
    return (m_left[k] > 1) || (m_lu(k) && !fl);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = NOP; m_mem[k] = NOP; m_wb[k] = NOP;
      m_exrw[k] = 1'b0; m_exmr[k] = 1'b0; m_memrw[k] = 1'b0; m_wbrw[k] = 1'b0;
      m_left[k] = 1;
    end
  endtask

  task automatic m_step();
    bit lu;
    for (int k = 0; k < 2; k++) begin
      lu = m_lu(k);
      m_wb[k] = m_mem[k];
      m_wbrw[k] = m_memrw[k];
      if (m_left[k] > 1) begin
        m_mem[k] = NOP;
        m_memrw[k] = 1'b0;
        m_left[k] = m_left[k] - 1;
      end else begin
        m_mem[k] = m_ex[k];
        m_memrw[k] = m_exrw[k] && (m_ex[k][11:7] != 5'd0);
        if (id_v && !fl && !lu) begin
          m_ex[k] = id_ins; m_exrw[k] = id_rw; m_exmr[k] = id_mr;
          m_left[k] = is_mul(id_ins) ? lat_of(k) : 1;
        end else begin
          m_ex[k] = NOP; m_exrw[k] = 1'b0; m_exmr[k] = 1'b0; m_left[k] = 1;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] ins, input logic v, input logic rw, input logic mr, input logic f);
    id_ins = ins; id_v = v; id_rw = rw; id_mr = mr; fl = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic gen(output logic [31:0] ins, output logic rw, output logic mr);
    logic [4:0] rd, rs1, rs2;
    logic [11:0] imm;
    int t;
    t = $urandom_range(0, 4);
    rd = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    imm = 12'($urandom);
    case (t)
      0: begin ins = {imm, rs1, 3'b010, rd, 7'b0000011}; rw = 1'b1; mr = 1'b1; end
      1: begin ins = {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011}; rw = 1'b1; mr = 1'b0; end
      2: begin ins = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011}; rw = 1'b1; mr = 1'b0; end
      3: begin ins = {imm, rs1, 3'b000, rd, 7'b0010011}; rw = 1'b1; mr = 1'b0; end
      default: begin ins = {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011}; rw = 1'b0; mr = 1'b0; end
    endcase
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    drive(ADDI9, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(MUL7, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(ADD6, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    total++; if (bus0.mul_busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b want 1", bus0.mul_busy); end
    rst = 1'b1;
    #1;
    total++; if (bus0.instruction_EX !== NOP) begin bad++; $display("FAIL rst_ex: got %h want %h", bus0.instruction_EX, NOP); end
    total++; if (bus0.instruction_MEM !== NOP) begin bad++; $display("FAIL rst_mem: got %h want %h", bus0.instruction_MEM, NOP); end
    total++; if (bus0.instruction_WB !== NOP) begin bad++; $display("FAIL rst_wb: got %h want %h", bus0.instruction_WB, NOP); end
    total++; if ({bus0.RegWrite_MEM, bus0.RegWrite_WB} !== 2'b00) begin bad++; $display("FAIL rst_rw: got %b%b want 00", bus0.RegWrite_MEM, bus0.RegWrite_WB); end
    total++; if ({bus0.stall_ID, bus0.mul_busy} !== 2'b00) begin bad++; $display("FAIL rst_stall_busy: got %b%b want 00", bus0.stall_ID, bus0.mul_busy); end
    total++; if (bus1.instruction_EX !== NOP) begin bad++; $display("FAIL rst_ex1: got %h want %h", bus1.instruction_EX, NOP); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++; if (bus0.instruction_EX !== ADD6) begin bad++; $display("FAIL rst_first_load: got %h want %h", bus0.instruction_EX, ADD6); end
    total++; if (bus0.mul_busy !== 1'b0) begin bad++; $display("FAIL rst_after_busy: got %b want 0", bus0.mul_busy); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(LW5, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (bus0.stall_ID !== 1'b0) begin bad++; $display("FAIL lu_pre_stall: got %b want 0", bus0.stall_ID); end
    tick();
    drive(ADD6, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (bus0.stall_ID !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", bus0.stall_ID); end
    tick();
    @(negedge clk);
    total++; if (bus0.stall_ID !== 1'b0) begin bad++; $display("FAIL lu_stall_once: got %b want 0", bus0.stall_ID); end
    total++; if (bus0.instruction_EX !== NOP) begin bad++; $display("FAIL lu_bubble: got %h want %h", bus0.instruction_EX, NOP); end
    total++; if (bus0.instruction_MEM !== LW5) begin bad++; $display("FAIL lu_mem: got %h want %h", bus0.instruction_MEM, LW5); end
    tick();
    @(negedge clk);
    total++; if (bus0.instruction_EX !== ADD6) begin bad++; $display("FAIL lu_add_ex: got %h want %h", bus0.instruction_EX, ADD6); end
    total++; if (bus0.instruction_WB !== LW5) begin bad++; $display("FAIL lu_lw_wb: got %h want %h", bus0.instruction_WB, LW5); end
  endtask

  task automatic test_mul();
    logic [31:0] e_ex, e_mem;
    do_reset();
    drive(ADDI9, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(MUL7, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(ADDI8, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e_ex = (i < 3) ? MUL7 : ADDI8;
      e_mem = (i == 0) ? ADDI9 : ((i == 3) ? MUL7 : NOP);
      total++; if (bus0.instruction_EX !== e_ex) begin bad++; $display("FAIL mul_ex c%0d: got %h want %h", i, bus0.instruction_EX, e_ex); end
      total++; if (bus0.instruction_MEM !== e_mem) begin bad++; $display("FAIL mul_mem c%0d: got %h want %h", i, bus0.instruction_MEM, e_mem); end
      total++; if (bus0.stall_ID !== (i < 2)) begin bad++; $display("FAIL mul_stall c%0d: got %b want %b", i, bus0.stall_ID, (i < 2)); end
      total++; if (bus0.mul_busy !== (i < 2)) begin bad++; $display("FAIL mul_busy c%0d: got %b want %b", i, bus0.mul_busy, (i < 2)); end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(LW5, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(ADD6, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    total++; if (bus0.stall_ID !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", bus0.stall_ID); end
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (bus0.instruction_EX !== NOP) begin bad++; $display("FAIL flush_ex: got %h want %h", bus0.instruction_EX, NOP); end
    total++; if (bus0.instruction_MEM !== LW5) begin bad++; $display("FAIL flush_mem: got %h want %h", bus0.instruction_MEM, LW5); end
  endtask

  task automatic test_x0();
    do_reset();
    drive(X0W, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(ADDI8, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (bus0.RegWrite_MEM !== 1'b0) begin bad++; $display("FAIL x0_rw_mem: got %b want 0", bus0.RegWrite_MEM); end
    tick();
    @(negedge clk);
    total++; if (bus0.RegWrite_MEM !== 1'b1) begin bad++; $display("FAIL x8_rw_mem: got %b want 1", bus0.RegWrite_MEM); end
    total++; if (bus0.RegWrite_WB !== 1'b0) begin bad++; $display("FAIL x0_rw_wb: got %b want 0", bus0.RegWrite_WB); end
    tick();
    @(negedge clk);
    total++; if (bus0.RegWrite_WB !== 1'b1) begin bad++; $display("FAIL x8_rw_wb: got %b want 1", bus0.RegWrite_WB); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] m2, e_ex;
    logic [5:0] pat;
    m2 = 32'h0252_8533; // mul x10,x5,x5
    pat = 6'b011011;
    // MUL_LAT=1 instance: no stalls, one EX cycle each.
    do_reset();
    drive(MUL7, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(m2, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    total++; if ({bus1.stall_ID, bus1.mul_busy} !== 2'b00) begin bad++; $display("FAIL b2b1_c0: got %b%b want 00", bus1.stall_ID, bus1.mul_busy); end
    total++; if (bus1.instruction_EX !== MUL7) begin bad++; $display("FAIL b2b1_ex0: got %h want %h", bus1.instruction_EX, MUL7); end
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    total++; if ({bus1.stall_ID, bus1.mul_busy} !== 2'b00) begin bad++; $display("FAIL b2b1_c1: got %b%b want 00", bus1.stall_ID, bus1.mul_busy); end
    total++; if (bus1.instruction_EX !== m2) begin bad++; $display("FAIL b2b1_ex1: got %h want %h", bus1.instruction_EX, m2); end
    tick();
    @(negedge clk);
    total++; if (bus1.instruction_WB !== MUL7) begin bad++; $display("FAIL b2b1_wb: got %h want %h", bus1.instruction_WB, MUL7); end
    // MUL_LAT=3 instance: 3 EX cycles each, no gap between them.
    do_reset();
    drive(MUL7, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(m2, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e_ex = (i < 3) ? MUL7 : m2;
      total++; if (bus0.instruction_EX !== e_ex) begin bad++; $display("FAIL b2b3_ex c%0d: got %h want %h", i, bus0.instruction_EX, e_ex); end
      total++; if (bus0.stall_ID !== pat[i]) begin bad++; $display("FAIL b2b3_stall c%0d: got %b want %b", i, bus0.stall_ID, pat[i]); end
      total++; if (bus0.mul_busy !== pat[i]) begin bad++; $display("FAIL b2b3_busy c%0d: got %b want %b", i, bus0.mul_busy, pat[i]); end
      tick();
      if (i == 2) drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic rw, mr, hold;
    logic [100:0] obs, exp_v;
    do_reset();
    m_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (k == 0) obs = {bus0.instruction_EX, bus0.instruction_MEM, bus0.instruction_WB,
                           bus0.RegWrite_MEM, bus0.RegWrite_WB, bus0.stall_ID, bus0.mul_busy};
        else        obs = {bus1.instruction_EX, bus1.instruction_MEM, bus1.instruction_WB,
                           bus1.RegWrite_MEM, bus1.RegWrite_WB, bus1.stall_ID, bus1.mul_busy};
        exp_v = {m_ex[k], m_mem[k], m_wb[k], m_memrw[k], m_wbrw[k], m_stall(k), (m_left[k] > 1)};
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL random inst%0d cyc%0d: got %h want %h", k, c, obs, exp_v);
        end
      end
      hold = m_stall(0);
      if (rst) rst = 1'b0;
      @(posedge clk);
      m_step();
      #1;
      fl = ($urandom_range(0, 9) == 0);
      if (!hold) begin
        gen(ins, rw, mr);
        id_ins = ins; id_rw = rw; id_mr = mr;
        id_v = ($urandom_range(0, 99) < 85);
      end
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        m_reset();
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul();
    test_flush();
    test_x0();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
